// File: rtl/ice_uart_deframer.sv
// ice_uart_deframer: receive-side ICE host-link command deframer.
// Parses type / id / length / payload frames from the UART receiver,
// buffers payload bytes in a small FIFO and answers each frame with a
// three-byte ACK (00 id 00) or NAK (01 id 00) into the UART transmitter.
module ice_uart_deframer #(
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_latch,
    output logic [7:0] frame_type,
    output logic [7:0] frame_id,
    output logic [7:0] frame_len,
    output logic       hdr_valid,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    input  logic       pl_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] resp_data,
    output logic       resp_latch,
    input  logic       resp_empty
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_ID  = 3'd1,
        ST_GET_LEN = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Per-byte transmit handshake: wait for an idle transmitter, strobe,
    // then see it go busy and come back idle before the next byte.
    typedef enum logic [1:0] {
        RP_WAIT_EMPTY = 2'd0,
        RP_WAIT_FALL  = 2'd1,
        RP_WAIT_RISE  = 2'd2
    } rphase_t;

    state_t           state_r, state_nx_s;
    rphase_t          phase_r, phase_nx_s;
    logic [7:0]       frame_type_r, frame_id_r, frame_len_r;
    logic             hdr_valid_r, frame_done_r, frame_err_r, resp_latch_r;
    logic [7:0]       resp_data_r;
    logic [7:0]       cnt_r;
    logic             err_r;
    logic [TMO_W-1:0] tmo_r;
    logic [1:0]       idx_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;

    logic cap_type_s, cap_id_s, cap_len_s, load_cnt_s, push_s, set_err_s;
    logic tmo_inc_s, flush_s, done_s, err_p_s, send_s, idx_inc_s, resp_end_s;
    logic pop_s, full_s, tmo_last_s;
    logic [7:0] resp_byte_s;

    assign pl_valid   = (wr_ptr_r != rd_ptr_r);
    assign pl_data    = mem_r[rd_ptr_r[AW-1:0]];
    assign pop_s      = pl_valid & pl_ready;
    assign full_s     = ((wr_ptr_r - rd_ptr_r) == PTR_W'(FIFO_DEPTH));
    assign tmo_last_s = (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));

    assign frame_type = frame_type_r;
    assign frame_id   = frame_id_r;
    assign frame_len  = frame_len_r;
    assign hdr_valid  = hdr_valid_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign resp_data  = resp_data_r;
    assign resp_latch = resp_latch_r;

    // Select the response byte for the current position in the reply.
    always_comb begin
        resp_byte_s = 8'h00;
        case (idx_r)
            2'd0:    resp_byte_s = err_r ? 8'h01 : 8'h00;
            2'd1:    resp_byte_s = frame_id_r;
            default: resp_byte_s = 8'h00;
        endcase
    end

    // Next-state and control decode for the frame FSM.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = phase_r;
        cap_type_s = 1'b0;
        cap_id_s   = 1'b0;
        cap_len_s  = 1'b0;
        load_cnt_s = 1'b0;
        push_s     = 1'b0;
        set_err_s  = 1'b0;
        tmo_inc_s  = 1'b0;
        flush_s    = 1'b0;
        done_s     = 1'b0;
        err_p_s    = 1'b0;
        send_s     = 1'b0;
        idx_inc_s  = 1'b0;
        resp_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_latch) begin
                    cap_type_s = 1'b1;
                    state_nx_s = ST_GET_ID;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GET_ID: begin
                if (rx_latch) begin
                    cap_id_s   = 1'b1;
                    state_nx_s = ST_GET_LEN;
                end else if (tmo_last_s) begin
                    set_err_s  = 1'b1;
                    state_nx_s = ST_DRAIN;
                end else begin
                    tmo_inc_s  = 1'b1;
                end
            end
            ST_GET_LEN: begin
                if (rx_latch) begin
                    cap_len_s = 1'b1;
                    if (rx_data == 8'h00) begin
                        state_nx_s = ST_DRAIN;
                    end else begin
                        load_cnt_s = 1'b1;
                        state_nx_s = ST_PAYLOAD;
                    end
                end else if (tmo_last_s) begin
                    set_err_s  = 1'b1;
                    state_nx_s = ST_DRAIN;
                end else begin
                    tmo_inc_s  = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (rx_latch) begin
                    if (full_s && !pop_s) begin
                        set_err_s  = 1'b1;
                        state_nx_s = ST_DRAIN;
                    end else begin
                        push_s = 1'b1;
                        if (cnt_r == 8'd1) begin
                            state_nx_s = ST_DRAIN;
                        end else begin
                            state_nx_s = ST_PAYLOAD;
                        end
                    end
                end else if (tmo_last_s) begin
                    set_err_s  = 1'b1;
                    state_nx_s = ST_DRAIN;
                end else begin
                    tmo_inc_s  = 1'b1;
                end
            end
            ST_DRAIN: begin
                phase_nx_s = RP_WAIT_EMPTY;
                if (err_r) begin
                    flush_s    = 1'b1;
                    err_p_s    = 1'b1;
                    state_nx_s = ST_RESP;
                end else if (!pl_valid) begin
                    done_s     = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_RESP: begin
                case (phase_r)
                    RP_WAIT_EMPTY: begin
                        if (resp_empty) begin
                            send_s     = 1'b1;
                            phase_nx_s = RP_WAIT_FALL;
                        end else begin
                            phase_nx_s = RP_WAIT_EMPTY;
                        end
                    end
                    RP_WAIT_FALL: begin
                        if (!resp_empty) begin
                            phase_nx_s = RP_WAIT_RISE;
                        end else begin
                            phase_nx_s = RP_WAIT_FALL;
                        end
                    end
                    RP_WAIT_RISE: begin
                        if (resp_empty) begin
                            phase_nx_s = RP_WAIT_EMPTY;
                            if (idx_r == 2'd2) begin
                                resp_end_s = 1'b1;
                                state_nx_s = ST_IDLE;
                            end else begin
                                idx_inc_s = 1'b1;
                            end
                        end else begin
                            phase_nx_s = RP_WAIT_RISE;
                        end
                    end
                    default: phase_nx_s = RP_WAIT_EMPTY;
                endcase
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state and response-phase registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            phase_r <= RP_WAIT_EMPTY;
        end else begin
            state_r <= state_nx_s;
            phase_r <= phase_nx_s;
        end
    end

    // Header capture, byte counter, timeout counter and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_type_r <= 8'h00;
            frame_id_r   <= 8'h00;
            frame_len_r  <= 8'h00;
            cnt_r        <= 8'h00;
            tmo_r        <= '0;
            err_r        <= 1'b0;
        end else begin
            if (cap_type_s) frame_type_r <= rx_data;
            if (cap_id_s)   frame_id_r   <= rx_data;
            if (cap_len_s)  frame_len_r  <= rx_data;
            if (load_cnt_s) begin
                cnt_r <= rx_data;
            end else if (push_s) begin
                cnt_r <= cnt_r - 8'd1;
            end
            // Any strobe or non-counting state leaves the counter at zero.
            tmo_r <= tmo_inc_s ? (tmo_r + TMO_W'(1)) : '0;
            if (set_err_s) begin
                err_r <= 1'b1;
            end else if (resp_end_s) begin
                err_r <= 1'b0;
            end
        end
    end

    // Payload FIFO storage and pointers; an error flush drops all contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= rx_data;
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (flush_s) begin
                rd_ptr_r <= wr_ptr_r;
            end else if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Registered pulse outputs and response byte sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            resp_latch_r <= 1'b0;
            resp_data_r  <= 8'h00;
            idx_r        <= 2'd0;
        end else begin
            hdr_valid_r  <= cap_len_s;
            frame_done_r <= done_s;
            frame_err_r  <= err_p_s;
            resp_latch_r <= send_s;
            if (send_s) resp_data_r <= resp_byte_s;
            if (state_r != ST_RESP || resp_end_s) begin
                idx_r <= 2'd0;
            end else if (idx_inc_s) begin
                idx_r <= idx_r + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ice_uart_deframer.sv
// Scoreboard bench for ice_uart_deframer: directed frames push expected
// headers, payload bytes, frame outcomes and response bytes into queues;
// a negedge monitor pops and compares whenever the DUT presents them, and
// also models the UART transmitter's busy period after each resp_latch.
module tb_ice_uart_deframer;

    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_latch;
    logic [7:0] frame_type, frame_id, frame_len, pl_data, resp_data;
    logic       hdr_valid, pl_valid, pl_ready, frame_done, frame_err;
    logic       resp_latch, resp_empty;
    logic       tx_busy, hold_tx;

    int checks   = 0;
    int failures = 0;
    int resp_cnt = 0;
    int busy_cnt = 0;
    int resp_target = 0;
    logic prev_latch = 1'b0;

    logic [23:0] exp_hdr [$];
    logic [7:0]  exp_pl  [$];
    logic        exp_end [$];
    logic [7:0]  exp_resp[$];

    assign resp_empty = !(tx_busy || hold_tx);

    always #5 clk = ~clk;

    ice_uart_deframer #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_latch(rx_latch),
        .frame_type(frame_type), .frame_id(frame_id), .frame_len(frame_len),
        .hdr_valid(hdr_valid), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .frame_done(frame_done), .frame_err(frame_err),
        .resp_data(resp_data), .resp_latch(resp_latch), .resp_empty(resp_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_latch = 1'b1;
        @(posedge clk); #1;
        rx_latch = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] id, input logic err);
        exp_end.push_back(err);
        exp_resp.push_back(err ? 8'h01 : 8'h00);
        exp_resp.push_back(id);
        exp_resp.push_back(8'h00);
        resp_target += 3;
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        while (resp_cnt < resp_target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, resp_cnt, resp_target);
        repeat (10) @(negedge clk);
    endtask

    // Scoreboard monitor and transmitter model.
    initial begin : monitor
        logic [23:0] eh;
        logic [7:0]  eb;
        logic        ee;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (hdr_valid) begin
                if (exp_hdr.size() == 0) begin
                    check("hdr_unexpected", 32'd1, 32'd0);
                end else begin
                    eh = exp_hdr.pop_front();
                    check("hdr_fields", {8'h00, frame_type, frame_id, frame_len}, {8'h00, eh});
                end
            end
            if (pl_valid && pl_ready) begin
                if (exp_pl.size() == 0) begin
                    check("pl_unexpected", {24'h0, pl_data}, 32'hFFFF_FFFF);
                end else begin
                    eb = exp_pl.pop_front();
                    check("pl_data", {24'h0, pl_data}, {24'h0, eb});
                end
            end
            if (frame_done || frame_err) begin
                if (exp_end.size() == 0) begin
                    check("end_unexpected", {30'h0, frame_err, frame_done}, 32'd0);
                end else begin
                    ee = exp_end.pop_front();
                    check("end_kind", {30'h0, frame_err, frame_done}, ee ? 32'd2 : 32'd1);
                end
            end
            if (resp_latch) begin
                check("resp_empty_at_latch", {31'h0, resp_empty}, 32'd1);
                check("resp_latch_gap", {31'h0, prev_latch}, 32'd0);
                if (exp_resp.size() == 0) begin
                    check("resp_unexpected", {24'h0, resp_data}, 32'hFFFF_FFFF);
                end else begin
                    eb = exp_resp.pop_front();
                    check("resp_byte", {24'h0, resp_data}, {24'h0, eb});
                end
                resp_cnt++;
                tx_busy  = 1'b1;
                busy_cnt = 4;
            end
            prev_latch = resp_latch;
        end
    end

    initial begin : stimulus
        int n;
        int base;
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_latch = 1'b0;
        pl_ready = 1'b1;
        tx_busy  = 1'b0;
        hold_tx  = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_hdr_regs", {8'h00, frame_type, frame_id, frame_len}, 32'd0);
        check("rst_pulses", {28'h0, hdr_valid, frame_done, frame_err, resp_latch}, 32'd0);
        check("rst_pl_valid", {31'h0, pl_valid}, 32'd0);
        check("rst_resp_data", {24'h0, resp_data}, 32'd0);
        reset = 1'b1;

        // Normal frame.
        exp_hdr.push_back(24'h5A0704);
        exp_pl.push_back(8'hDE); exp_pl.push_back(8'hAD);
        exp_pl.push_back(8'hBE); exp_pl.push_back(8'hEF);
        expect_frame(8'h07, 1'b0);
        send_byte(8'h5A); send_byte(8'h07); send_byte(8'h04);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_resp("normal_resp_count");

        // Zero-length frame.
        exp_hdr.push_back(24'h013C00);
        expect_frame(8'h3C, 1'b0);
        send_byte(8'h01); send_byte(8'h3C); send_byte(8'h00);
        wait_resp("zero_len_resp_count");

        // Overflow: consumer stalled, four bytes fill the FIFO, the fifth overflows.
        pl_ready = 1'b0;
        exp_hdr.push_back(24'h203106);
        expect_frame(8'h31, 1'b1);
        send_byte(8'h20); send_byte(8'h31); send_byte(8'h06);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        check("ovf_fifo_holds", {31'h0, pl_valid}, 32'd1);
        check("ovf_head_byte", {24'h0, pl_data}, 32'h11);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        check("ovf_flushed", {31'h0, pl_valid}, 32'd0);
        send_byte(8'h66);
        @(negedge clk);
        check("ovf_6th_ignored", {31'h0, pl_valid}, 32'd0);
        wait_resp("ovf_resp_count");
        pl_ready = 1'b1;

        // Timeout after the id byte.
        expect_frame(8'h22, 1'b1);
        send_byte(8'h10); send_byte(8'h22);
        n = 0;
        while (!frame_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        // n-1 rising edges have elapsed since the id strobe edge.
        check("tmo_seen", {31'h0, frame_err}, 32'd1);
        check("tmo_latency_ok", {31'h0, ((n - 1) >= TMO) && ((n - 1) <= TMO + 2)}, 32'd1);
        wait_resp("tmo_resp_count");

        // Next frame after the timeout, with a back-pressured transmitter.
        exp_hdr.push_back(24'h420901);
        exp_pl.push_back(8'h77);
        expect_frame(8'h09, 1'b0);
        send_byte(8'h42); send_byte(8'h09); send_byte(8'h01); send_byte(8'h77);
        n = 0;
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_done_seen", {31'h0, frame_done}, 32'd1);
        hold_tx = 1'b1;
        base = resp_cnt;
        repeat (500) @(negedge clk);
        check("bp_no_latch_while_busy", resp_cnt, base);
        hold_tx = 1'b0;
        wait_resp("bp_resp_count");
        check("bp_three_latches", resp_cnt - base, 32'd3);

        // Reset in the middle of the payload.
        exp_hdr.push_back(24'h334404);
        exp_pl.push_back(8'hAA); exp_pl.push_back(8'hBB);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h04);
        send_byte(8'hAA); send_byte(8'hBB);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_hdr_regs", {8'h00, frame_type, frame_id, frame_len}, 32'd0);
        check("midrst_pulses", {28'h0, hdr_valid, frame_done, frame_err, resp_latch}, 32'd0);
        check("midrst_pl_valid", {31'h0, pl_valid}, 32'd0);
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        exp_hdr.push_back(24'h665501);
        exp_pl.push_back(8'h99);
        expect_frame(8'h55, 1'b0);
        send_byte(8'h66); send_byte(8'h55); send_byte(8'h01); send_byte(8'h99);
        wait_resp("post_rst_resp_count");

        check("hdr_q_drained", exp_hdr.size(), 32'd0);
        check("pl_q_drained", exp_pl.size(), 32'd0);
        check("end_q_drained", exp_end.size(), 32'd0);
        check("resp_q_drained", exp_resp.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
